// File: rtl/common_gnss_types_pkg.sv
// Purpose: shared GNSS channel types (accumulators, discriminators, tracking-loop state).
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
// Contents: acc_t, disc_t, track_state_t, mag17() helper.
package common_gnss_types_pkg;

  typedef logic signed [15:0] acc_t;
  typedef logic signed [17:0] disc_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } track_state_t;

  // |a| as 17-bit unsigned, so |-32768| = 32768 is representable.
  function automatic logic [16:0] mag17(input acc_t a);
    logic signed [16:0] w_x;
    w_x = {a[15], a};
    return w_x[16] ? $unsigned(-w_x) : $unsigned(w_x);
  endfunction

endpackage

// File: rtl/l1ca_track_loop_if.sv
// Purpose: channel <-> tracking-loop bundle: epoch dump in, NCO rates and status out.
// Latency: n/a (wires only).
// Backpressure: none; epoch is a single-cycle strobe, outputs are registered levels/pulses.
// Modports: master = channel/software side, slave = l1ca_track_loop.
interface l1ca_track_loop_if import common_gnss_types_pkg::*; ();

  logic        start;
  logic        clear;
  logic [31:0] code_rate_init;
  logic [31:0] lo_rate_init;
  logic        epoch;
  acc_t        ie, qe, ip, qp, il, ql;

  logic [31:0] code_rate;
  logic [31:0] lo_rate;
  logic        update;
  acc_t        ip_dump, qp_dump;
  disc_t       dll_err, pll_err;
  logic        locked;

  modport master (
    output start, clear, code_rate_init, lo_rate_init, epoch,
    output ie, qe, ip, qp, il, ql,
    input  code_rate, lo_rate, update, ip_dump, qp_dump, dll_err, pll_err, locked
  );

  modport slave (
    input  start, clear, code_rate_init, lo_rate_init, epoch,
    input  ie, qe, ip, qp, il, ql,
    output code_rate, lo_rate, update, ip_dump, qp_dump, dll_err, pll_err, locked
  );

endinterface

// File: rtl/l1ca_track_disc.sv
// Purpose: stages 1-3 of the tracking loop: accumulator latch, E/L envelopes, DLL/Costas discriminators.
// Latency: 3 cycles from i_vld to o_vld.
// Backpressure: none; i_flush kills every in-flight stage in the cycle it is asserted.
// Ports: i_vld + six accumulators in; o_vld + dll/pll errors out; o_ip_dump/o_qp_dump = stage-1 prompt latch.
// Macro L1CA_TRACK_LOCK_EN adds o_ip_strong (|ip| >= LOCK_THRESH, aligned with o_vld).
module l1ca_track_disc import common_gnss_types_pkg::*; #(
  parameter logic [15:0] LOCK_THRESH = 16'd2000
) (
  input  logic  clk,
  input  logic  nrst,
  input  logic  i_flush,
  input  logic  i_vld,
  input  acc_t  i_ie,
  input  acc_t  i_qe,
  input  acc_t  i_ip,
  input  acc_t  i_qp,
  input  acc_t  i_il,
  input  acc_t  i_ql,
  output logic  o_vld,
  output acc_t  o_ip_dump,
  output acc_t  o_qp_dump,
  output disc_t o_dll_err,
  output disc_t o_pll_err
`ifdef L1CA_TRACK_LOCK_EN
  ,
  output logic  o_ip_strong
`endif
);

  // stage 1: raw accumulator latch
  logic        r_s1_vld;
  acc_t        r_s1_ie, r_s1_qe, r_s1_ip, r_s1_qp, r_s1_il, r_s1_ql;
  // stage 2: envelopes, prompt carried for the discriminator
  logic        r_s2_vld;
  logic [16:0] r_s2_e, r_s2_l;
  acc_t        r_s2_ip, r_s2_qp;
  // stage 3: errors
  logic        r_s3_vld;
  disc_t       r_s3_dll, r_s3_pll;

  disc_t       w_qp18;
  assign w_qp18 = {{2{r_s2_qp[15]}}, r_s2_qp};

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_s1_vld <= 1'b0;
      r_s1_ie  <= '0;
      r_s1_qe  <= '0;
      r_s1_ip  <= '0;
      r_s1_qp  <= '0;
      r_s1_il  <= '0;
      r_s1_ql  <= '0;
      r_s2_vld <= 1'b0;
      r_s2_e   <= '0;
      r_s2_l   <= '0;
      r_s2_ip  <= '0;
      r_s2_qp  <= '0;
      r_s3_vld <= 1'b0;
      r_s3_dll <= '0;
      r_s3_pll <= '0;
    end else begin
      r_s1_vld <= i_vld & ~i_flush;
      r_s2_vld <= r_s1_vld & ~i_flush;
      r_s3_vld <= r_s2_vld & ~i_flush;

      if (i_vld && !i_flush) begin
        r_s1_ie <= i_ie;
        r_s1_qe <= i_qe;
        r_s1_ip <= i_ip;
        r_s1_qp <= i_qp;
        r_s1_il <= i_il;
        r_s1_ql <= i_ql;
      end

      if (r_s1_vld && !i_flush) begin
        // 17-bit sums: max 32768 + 32768 = 65536 still fits
        r_s2_e  <= mag17(r_s1_ie) + mag17(r_s1_qe);
        r_s2_l  <= mag17(r_s1_il) + mag17(r_s1_ql);
        r_s2_ip <= r_s1_ip;
        r_s2_qp <= r_s1_qp;
      end

      if (r_s2_vld && !i_flush) begin
        r_s3_dll <= $signed({1'b0, r_s2_e}) - $signed({1'b0, r_s2_l});
        // Costas sign discriminator; 18 bits so -(-32768) does not wrap
        r_s3_pll <= r_s2_ip[15] ? -w_qp18 : w_qp18;
      end
    end
  end

`ifdef L1CA_TRACK_LOCK_EN
  logic r_s3_strong;
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_s3_strong <= 1'b0;
    end else if (r_s2_vld && !i_flush) begin
      r_s3_strong <= (mag17(r_s2_ip) >= {1'b0, LOCK_THRESH});
    end
  end
  assign o_ip_strong = r_s3_strong;
`endif

  assign o_vld     = r_s3_vld;
  assign o_ip_dump = r_s1_ip;
  assign o_qp_dump = r_s1_qp;
  assign o_dll_err = r_s3_dll;
  assign o_pll_err = r_s3_pll;

endmodule

// File: rtl/l1ca_track_loop.sv
// Purpose: L1 C/A closed-loop tracking controller: DLL/Costas discriminators, loop filter, NCO rate drive.
// Latency: 4 cycles from epoch to code_rate/lo_rate/update.
// Backpressure: none; fully pipelined, start/clear flush all in-flight epochs.
// Ports: clk, nrst (sync, active-low), bus (l1ca_track_loop_if.slave).
// Macro L1CA_TRACK_LOCK_EN builds the 4-bit hysteretic lock detector; otherwise locked is 0.
module l1ca_track_loop import common_gnss_types_pkg::*; #(
  parameter int          DLL_KP_SHIFT = 4,
  parameter int          PLL_KP_SHIFT = 10,
  parameter int          PLL_KI_SHIFT = 6,
  parameter logic [15:0] LOCK_THRESH  = 16'd2000
) (
  input logic              clk,
  input logic              nrst,
  l1ca_track_loop_if.slave bus
);

  track_state_t r_state, w_state_nxt;
  logic         r_skip;
  logic         w_take;   // epoch enters the pipeline
  logic         w_drop;   // first (partial) epoch after start, discarded
  logic         w_flush;

  logic         w_d_vld;
  disc_t        w_dll, w_pll;
  logic         w_s4;

  logic [31:0]  r_code_rate, r_lo_rate, r_lo_int;
  logic         r_update;
  disc_t        r_dll_err, r_pll_err;

  logic signed [31:0] w_dll_ext, w_pll_ext;
  logic [31:0]  w_code_corr, w_lo_pcorr, w_lo_icorr, w_lo_int_nxt;

  // start and clear both restart the pipeline
  assign w_flush = bus.clear | bus.start;

  always_ff @(posedge clk) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_drop      = 1'b0;
    if (bus.clear) begin
      w_state_nxt = IDLE;
    end else if (bus.start) begin
      w_state_nxt = RUN;
    end else if (r_state == RUN && bus.epoch) begin
      if (r_skip) w_drop = 1'b1;
      else        w_take = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst)                       r_skip <= 1'b1;
    else if (bus.start && !bus.clear) r_skip <= 1'b1;
    else if (w_drop)                 r_skip <= 1'b0;
  end

`ifdef L1CA_TRACK_LOCK_EN
  logic w_ip_strong;
`endif

  l1ca_track_disc #(
    .LOCK_THRESH (LOCK_THRESH)
  ) u_disc (
    .clk       (clk),
    .nrst      (nrst),
    .i_flush   (w_flush),
    .i_vld     (w_take),
    .i_ie      (bus.ie),
    .i_qe      (bus.qe),
    .i_ip      (bus.ip),
    .i_qp      (bus.qp),
    .i_il      (bus.il),
    .i_ql      (bus.ql),
    .o_vld     (w_d_vld),
    .o_ip_dump (bus.ip_dump),
    .o_qp_dump (bus.qp_dump),
    .o_dll_err (w_dll),
    .o_pll_err (w_pll)
`ifdef L1CA_TRACK_LOCK_EN
    ,
    .o_ip_strong (w_ip_strong)
`endif
  );

  // stage 4: loop filter
  assign w_s4         = w_d_vld & ~w_flush;
  assign w_dll_ext    = {{14{w_dll[17]}}, w_dll};
  assign w_pll_ext    = {{14{w_pll[17]}}, w_pll};
  assign w_code_corr  = $unsigned(w_dll_ext <<< DLL_KP_SHIFT);
  assign w_lo_icorr   = $unsigned(w_pll_ext <<< PLL_KI_SHIFT);
  assign w_lo_pcorr   = $unsigned(w_pll_ext <<< PLL_KP_SHIFT);
  assign w_lo_int_nxt = r_lo_int + w_lo_icorr;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_code_rate <= '0;
      r_lo_rate   <= '0;
      r_lo_int    <= '0;
      r_update    <= 1'b0;
      r_dll_err   <= '0;
      r_pll_err   <= '0;
    end else begin
      r_update <= 1'b0;
      if (bus.clear || (r_state == IDLE && !bus.start)) begin
        // open loop: rates shadow the nominal inputs
        r_code_rate <= bus.code_rate_init;
        r_lo_rate   <= bus.lo_rate_init;
      end else if (bus.start) begin
        r_code_rate <= bus.code_rate_init;
        r_lo_rate   <= bus.lo_rate_init;
        r_lo_int    <= bus.lo_rate_init;
      end else if (w_s4) begin
        // DLL is proportional-only around the nominal code rate
        r_code_rate <= bus.code_rate_init + w_code_corr;
        r_lo_int    <= w_lo_int_nxt;
        r_lo_rate   <= w_lo_int_nxt + w_lo_pcorr;
        r_update    <= 1'b1;
        r_dll_err   <= w_dll;
        r_pll_err   <= w_pll;
      end
    end
  end

`ifdef L1CA_TRACK_LOCK_EN
  logic [3:0] r_lock_cnt, w_lock_cnt_nxt;
  logic       r_locked;

  always_comb begin
    w_lock_cnt_nxt = r_lock_cnt;
    if (w_ip_strong) begin
      if (r_lock_cnt != 4'd15) w_lock_cnt_nxt = r_lock_cnt + 4'd1;
    end else begin
      if (r_lock_cnt != 4'd0)  w_lock_cnt_nxt = r_lock_cnt - 4'd1;
    end
  end

  // set at full count, clear only at empty: hysteresis between the two
  always_ff @(posedge clk) begin
    if (!nrst || w_flush) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else if (w_s4) begin
      r_lock_cnt <= w_lock_cnt_nxt;
      if (w_lock_cnt_nxt == 4'd15)     r_locked <= 1'b1;
      else if (w_lock_cnt_nxt == 4'd0) r_locked <= 1'b0;
    end
  end

  assign bus.locked = r_locked;
`else
  assign bus.locked = 1'b0;
`endif

  assign bus.code_rate = r_code_rate;
  assign bus.lo_rate   = r_lo_rate;
  assign bus.update    = r_update;
  assign bus.dll_err   = r_dll_err;
  assign bus.pll_err   = r_pll_err;

endmodule

// File: tb/tb_l1ca_track_loop.sv
// Purpose: self-checking bench for l1ca_track_loop: scoreboard of expected updates from a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_l1ca_track_loop;
  import common_gnss_types_pkg::*;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  l1ca_track_loop_if bus ();

  l1ca_track_loop dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [31:0] cr;
    logic [31:0] lr;
    int          dll;
    int          pll;
    logic        lk;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  // behavioural model state
  bit          m_run  = 0;
  bit          m_skip = 1;
  logic [31:0] m_lo_int = 0;
  logic [31:0] m_cr_init = 0;
  int          m_cnt = 0;
  bit          m_lk  = 0;
  int          last_ip = 0, last_qp = 0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d (0x%08h) required=%0d (0x%08h)", nm, act, act, req, req);
    end
  endtask

  // monitor: every update pulse must match the oldest expected result
  always @(negedge clk) begin
    if (nrst === 1'b1 && bus.update === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_update actual=1 required=0");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_code_rate", bus.code_rate, e.cr);
        chk("sb_lo_rate", bus.lo_rate, e.lr);
        chk("sb_dll_err", 32'(int'(bus.dll_err)), 32'(e.dll));
        chk("sb_pll_err", 32'(int'(bus.pll_err)), 32'(e.pll));
        chk("sb_locked", 32'(bus.locked), 32'(e.lk));
      end
    end
  end

  task automatic lock_reset();
    m_cnt = 0;
    m_lk  = 0;
  endtask

  task automatic do_start(input logic [31:0] cr, input logic [31:0] lr);
    @(negedge clk);
    bus.epoch = 1'b0;
    bus.start = 1'b1;
    bus.code_rate_init = cr;
    bus.lo_rate_init = lr;
    m_run = 1; m_skip = 1; m_lo_int = lr; m_cr_init = cr;
    lock_reset();
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    m_run = 0;
    lock_reset();
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  // drive one epoch cycle; consecutive calls give back-to-back epochs
  task automatic ep(input int ie, input int qe, input int ip, input int qp,
                    input int il, input int ql, input bit kill);
    exp_t e;
    int   dll, pll;
    @(negedge clk);
    bus.epoch = 1'b1;
    bus.ie = 16'(ie); bus.qe = 16'(qe); bus.ip = 16'(ip);
    bus.qp = 16'(qp); bus.il = 16'(il); bus.ql = 16'(ql);
    if (m_run) begin
      if (m_skip) begin
        m_skip = 0;
      end else if (!kill) begin
        dll = iabs(ie) + iabs(qe) - iabs(il) - iabs(ql);
        pll = (ip >= 0) ? qp : -qp;
        m_lo_int = m_lo_int + 32'(pll * 64);
        e.cr  = m_cr_init + 32'(dll * 16);
        e.lr  = m_lo_int + 32'(pll * 1024);
        e.dll = dll;
        e.pll = pll;
`ifdef L1CA_TRACK_LOCK_EN
        if (iabs(ip) >= 2000) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        else                  m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
        if (m_cnt == 15)     m_lk = 1;
        else if (m_cnt == 0) m_lk = 0;
`endif
        e.lk = m_lk;
        q.push_back(e);
        last_ip = ip;
        last_qp = qp;
      end
    end
  endtask

  task automatic quiet(input int n);
    @(negedge clk);
    bus.epoch = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // loop open: new inits must show up on the rates one cycle later
  task automatic chk_follow(input string nm);
    logic [31:0] cr, lr;
    cr = $urandom;
    lr = $urandom;
    @(negedge clk);
    bus.code_rate_init = cr;
    bus.lo_rate_init = lr;
    @(negedge clk);
    chk({nm, "_code"}, bus.code_rate, cr);
    chk({nm, "_lo"}, bus.lo_rate, lr);
  endtask

  function automatic int rnd_acc();
    logic [15:0] v;
    v = 16'($urandom_range(0, 65535));
    return int'($signed(v));
  endfunction

  initial begin
    bus.start = 0; bus.clear = 0; bus.epoch = 0;
    bus.code_rate_init = 32'd5; bus.lo_rate_init = 32'd7;
    bus.ie = 0; bus.qe = 0; bus.ip = 0; bus.qp = 0; bus.il = 0; bus.ql = 0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_code_rate", bus.code_rate, 0);
    chk("rst_lo_rate", bus.lo_rate, 0);
    chk("rst_update", 32'(bus.update), 0);
    chk("rst_ip_dump", 32'(int'(bus.ip_dump)), 0);
    chk("rst_dll_err", 32'(int'(bus.dll_err)), 0);
    chk("rst_locked", 32'(bus.locked), 0);
    nrst = 1'b1;
    chk_follow("idle_follow");

    // epoch in IDLE is ignored
    ep(100, 0, 200, 10, 50, 0, 0);
    quiet(8);

    // directed: base setup, then two identical epochs
    do_start(32'd228841226, 32'h1000_0000);
    chk("start_code", bus.code_rate, 32'd228841226);
    ep(1, 2, 3, 4, 5, 6, 0);
    quiet(8);
    chk("skip_code", bus.code_rate, 32'd228841226);
    chk("skip_lo", bus.lo_rate, 32'h1000_0000);
    ep(100, 0, 200, 10, 50, 0, 0);
    quiet(8);
    chk("d1_code", bus.code_rate, 32'd228842026);
    chk("d1_lo", bus.lo_rate, 32'h1000_2A80);
    chk("d1_ip_dump", 32'(int'(bus.ip_dump)), 32'(200));
    ep(100, 0, 200, 10, 50, 0, 0);
    quiet(8);
    chk("d2_lo", bus.lo_rate, 32'h1000_2D00);
    chk("d2_code", bus.code_rate, 32'd228842026);

    // directed: negative prompt flips the Costas error
    do_start(32'd228841226, 32'h1000_0000);
    ep(0, 0, 0, 0, 0, 0, 0);
    quiet(3);
    ep(0, 0, -200, 10, 0, 0, 0);
    quiet(8);
    chk("d3_pll", 32'(int'(bus.pll_err)), 32'(-10));
    chk("d3_lo", bus.lo_rate, 32'h0FFF_D580);

    // magnitude corner: -32768 on every input
    ep(-32768, -32768, -32768, -32768, 0, 0, 0);
    quiet(8);
    chk("corner_dll", 32'(int'(bus.dll_err)), 32'(65536));
    chk("corner_pll", 32'(int'(bus.pll_err)), 32'(32768));

    // clear two cycles after an epoch kills it
    ep(300, 0, 200, 20, 0, 0, 1);
    quiet(0);
    do_clear();
    quiet(6);
    chk_follow("clear_follow");

    // start and clear together: loop stays open
    @(negedge clk);
    bus.start = 1'b1; bus.clear = 1'b1;
    m_run = 0; lock_reset();
    @(negedge clk);
    bus.start = 1'b0; bus.clear = 1'b0;
    ep(10, 0, 10, 1, 0, 0, 0);
    quiet(2);
    ep(10, 0, 10, 1, 0, 0, 0);
    quiet(8);
    chk_follow("sc_follow");

    // randomized run, mixing back-to-back and spaced epochs
    do_start($urandom, $urandom);
    ep(rnd_acc(), rnd_acc(), rnd_acc(), rnd_acc(), rnd_acc(), rnd_acc(), 0);
    for (int i = 0; i < 60; i++) begin
      ep(rnd_acc(), rnd_acc(), rnd_acc(), rnd_acc(), rnd_acc(), rnd_acc(), 0);
      if ($urandom_range(0, 2) == 0) quiet($urandom_range(0, 5));
    end
    quiet(8);
    chk("rnd_ip_dump", 32'(int'(bus.ip_dump)), 32'(last_ip));
    chk("rnd_qp_dump", 32'(int'(bus.qp_dump)), 32'(last_qp));
    chk("rnd_locked", 32'(bus.locked), 32'(m_lk));

`ifdef L1CA_TRACK_LOCK_EN
    do_start(32'd1000, 32'd2000);
    ep(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) ep(0, 0, 3000, 5, 0, 0, 0);
    quiet(8);
    chk("lock_set", 32'(bus.locked), 1);
    for (int i = 0; i < 14; i++) ep(0, 0, 100, 5, 0, 0, 0);
    quiet(8);
    chk("lock_hold", 32'(bus.locked), 1);
    ep(0, 0, 100, 5, 0, 0, 0);
    quiet(8);
    chk("lock_drop", 32'(bus.locked), 0);
`endif

    do_clear();
    quiet(4);
    chk("sb_drained", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l1ca_track_loop.md
# l1ca_track_loop

Closed-loop tracking controller for one L1 C/A channel. It sits directly downstream of the channel correlator: it consumes the per-epoch early/prompt/late I/Q accumulator dumps and the epoch strobe, and forms DLL (early-minus-late envelope) and Costas PLL discriminators. It filters both discriminators and drives the channel's `code_rate` and `lo_rate` NCO inputs, and it also provides a prompt dump and a lock indication for software.

## Interface
- `DLL_KP_SHIFT`, default 4: left shift applied to the DLL error for the code-rate correction.
- `PLL_KP_SHIFT`, default 10: proportional left shift applied to the PLL error.
- `PLL_KI_SHIFT`, default 6: integral left shift applied to the PLL error.
- `LOCK_THRESH`, default 16'd2000: lock threshold on |ip|.
- Reset `nrst` is synchronous and active-low; the clock is `clk`.
- `clk`, in, 1: clock.
- `nrst`, in, 1: synchronous active-low reset.
- `start`, in, 1: load initial rates and close the loop.
- `clear`, in, 1: open the loop and return to IDLE.
- `code_rate_init`, in, 32: nominal code NCO rate.
- `lo_rate_init`, in, 32: initial carrier NCO rate.
- `epoch`, in, 1: single-cycle epoch pulse from the channel.
- `ie, qe, ip, qp, il, ql`, in, acc_t (16-bit signed): accumulators. They are valid in the `epoch` cycle.
- `code_rate`, out, 32: code NCO rate sent to the channel.
- `lo_rate`, out, 32: carrier NCO rate sent to the channel.
- `update`, out, 1: one-cycle pulse when the rates change.
- `ip_dump, qp_dump`, out, acc_t: latched prompt I/Q from the last processed epoch.
- `dll_err`, out, disc_t (18-bit signed): last DLL error.
- `pll_err`, out, disc_t: last PLL error.
- `locked`, out, 1: lock indicator.

## Operation
- States are IDLE and RUN.
- IDLE → RUN on `start & ~clear`. Any state → IDLE on `clear`, and `clear` takes priority over `start`.
- On `start`:
  - `code_rate ← code_rate_init`.
  - `lo_rate ← lo_rate_init`.
  - The internal integrator `lo_int ← lo_rate_init`.
  - The pipeline is flushed and the `skip` flag is set.
- A `start` received in RUN restarts the loop the same way.
- In IDLE, `code_rate` and `lo_rate` track the `_init` inputs one cycle later. `epoch` is ignored.
- In RUN, the first `epoch` after `start` (partial integration) is discarded and clears `skip`. Every later epoch is processed.
- Stage 1 latches the six accumulators. `ip_dump` and `qp_dump` update here.
- Stage 2 computes E = |ie|+|qe| and L = |il|+|ql|, each 17-bit unsigned. |−32768| = 32768 with no overflow.
- Stage 3 computes the errors:
  - `dll_err = E − L`.
  - `pll_err = qp` if ip ≥ 0, else `−qp` (Costas sign discriminator).
- Stage 4 updates the rates:
  - `code_rate = code_rate_init + (sext32(dll_err) <<< DLL_KP_SHIFT)`.
  - `lo_int += sext32(pll_err) <<< PLL_KI_SHIFT`.
  - `lo_rate = lo_int_new + (sext32(pll_err) <<< PLL_KP_SHIFT)`.
  - All sums wrap modulo 2^32.
- Sign convention: E > L raises `code_rate`, and positive `pll_err` raises `lo_rate`.
- The pipeline is fully pipelined, so back-to-back epochs are all processed. In practice epochs are about 19k cycles apart.
- `clear` mid-pipeline kills all in-flight stages; no `update` is emitted.

## Timing
- `epoch` at cycle T:
  - The latch is visible at T+1.
  - E and L are ready at T+2.
  - The errors are ready at T+3.
  - `code_rate`, `lo_rate` and `update` are registered at T+4.
- Latency is 4 cycles.
- Reset values: state IDLE; all outputs 0; `lo_int` 0; `skip` 1; lock counter 0.

## Configuration
- With `L1CA_TRACK_LOCK_EN` defined:
  - A 4-bit saturating lock counter is built in.
  - At stage 4 of each processed epoch, the counter increments if |ip| ≥ `LOCK_THRESH`, else it decrements.
  - `locked` sets when the counter reaches 15 and clears at 0, giving hysteresis.
  - `clear` and `start` zero both the counter and `locked`.
- Without `L1CA_TRACK_LOCK_EN`, `locked` is tied to 0 and no counter logic is built.

## Structure
- `common_gnss_types_pkg` gains `disc_t` (logic signed [17:0]) and `track_state_t` (IDLE, RUN). It reuses `acc_t`.
- Sub-module `l1ca_track_disc` holds stages 1–3: the latch, magnitudes and discriminators, with a valid-in/valid-out pipeline. The loop filter, FSM and lock detector stay in the top module.

## Test plan
- Base setup for the first three scenarios: `start` with `code_rate_init` = 228841226 and `lo_rate_init` = 0x1000_0000, followed by one discarded epoch. The accumulator values listed are then presented in the `epoch` cycle.
- Base setup, then ie=100, qe=0, il=50, ql=0, ip=200, qp=10 → at T+4 `update` pulses, `dll_err`=50, `pll_err`=10, `code_rate`=228842026, `lo_rate`=0x1000_2A80.
- A second identical epoch → `lo_rate`=0x1000_2D00 and `code_rate` unchanged at 228842026.
- Base setup, then ip=−200, qp=10 → `pll_err`=−10 and `lo_rate`=0x0FFF_D580.
- `start` followed by the first epoch → no `update` and the rates stay at their init values. Epoch in IDLE → no `update`.
- `clear` at T+2 of an epoch → no `update`, state IDLE, and the rates follow the inits.
- `start` and `clear` in the same cycle → state stays IDLE.
- With `L1CA_TRACK_LOCK_EN` defined, 15 epochs at ip=3000 → `locked`=1. Then 14 epochs at ip=100 → still 1, and the 15th → 0.
